// File: rtl/reg_file_8.sv
// reg_file_8: register file with main and alternate banks (A/F and BC/DE/HL).
// Two registered read ports with write-first bypass, one write port,
// a dedicated flag load path, and bank exchange strobes.
// Register index encoding: 0=B 1=C 2=D 3=E 4=H 5=L 6=F 7=A.
module reg_file_8 #(
  parameter logic [7:0] RESET_AF = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  rd_a_sel,
  input  logic [2:0]  rd_b_sel,
  output logic [7:0]  rd_a_data,
  output logic [7:0]  rd_b_data,
  input  logic        wr_en,
  input  logic [2:0]  wr_sel,
  input  logic [7:0]  wr_data,
  input  logic        flag_we,
  input  logic [7:0]  flag_data,
  input  logic        ex_af,
  input  logic        exx,
  output logic [15:0] hl_out
);

  localparam logic [2:0] IDX_F = 3'd6;
  localparam logic [2:0] IDX_A = 3'd7;

  // Storage: index [bank] for A/F, [bank][reg] for B..L
  logic [1:0][7:0]      regA_q, regA_d;
  logic [1:0][7:0]      regF_q, regF_d;
  logic [1:0][5:0][7:0] gpReg_q, gpReg_d;
  logic                 afBank_q, afBank_d;
  logic                 gpBank_q, gpBank_d;
  logic [7:0]           rdA_q, rdA_d;
  logic [7:0]           rdB_q, rdB_d;

  // Read of the currently active bank, before any same-cycle update
  function automatic logic [7:0] readReg(input logic [2:0] sel);
    logic [7:0] val;
    case (sel)
      IDX_A:   val = regA_q[afBank_q];
      IDX_F:   val = regF_q[afBank_q];
      default: val = gpReg_q[gpBank_q][sel];
    endcase
    return val;
  endfunction

  // Read port value with write-first bypass; a flag load outranks a plain write to F
  function automatic logic [7:0] readPort(input logic [2:0] sel);
    logic [7:0] val;
    if (flag_we && (sel == IDX_F)) begin
      val = flag_data;
    end else if (wr_en && (wr_sel == sel)) begin
      val = wr_data;
    end else begin
      val = readReg(sel);
    end
    return val;
  endfunction

  // Next state: writes land in the pre-swap bank, then the bank bits toggle
  always_comb begin
    regA_d   = regA_q;
    regF_d   = regF_q;
    gpReg_d  = gpReg_q;
    afBank_d = afBank_q ^ ex_af;
    gpBank_d = gpBank_q ^ exx;
    rdA_d    = readPort(rd_a_sel);
    rdB_d    = readPort(rd_b_sel);

    if (wr_en) begin
      case (wr_sel)
        IDX_A:   regA_d[afBank_q] = wr_data;
        IDX_F:   regF_d[afBank_q] = wr_data;
        default: gpReg_d[gpBank_q][wr_sel] = wr_data;
      endcase
    end

    if (flag_we) begin
      regF_d[afBank_q] = flag_data;
    end
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regA_q   <= {2{RESET_AF}};
      regF_q   <= {2{RESET_AF}};
      gpReg_q  <= '0;
      afBank_q <= 1'b0;
      gpBank_q <= 1'b0;
      rdA_q    <= 8'h00;
      rdB_q    <= 8'h00;
    end else begin
      regA_q   <= regA_d;
      regF_q   <= regF_d;
      gpReg_q  <= gpReg_d;
      afBank_q <= afBank_d;
      gpBank_q <= gpBank_d;
      rdA_q    <= rdA_d;
      rdB_q    <= rdB_d;
    end
  end

  assign rd_a_data = rdA_q;
  assign rd_b_data = rdB_q;
  assign hl_out    = {gpReg_q[gpBank_q][4], gpReg_q[gpBank_q][5]};

endmodule

// File: tb/tb_reg_file_8.sv
// tb_reg_file_8: directed table-driven bench for reg_file_8, plus
// hand-written sequences for reset behaviour.
module tb_reg_file_8;

  typedef struct {
    logic [2:0]  rdA;
    logic [2:0]  rdB;
    logic        wrEn;
    logic [2:0]  wrSel;
    logic [7:0]  wrData;
    logic        flagWe;
    logic [7:0]  flagData;
    logic        exAf;
    logic        exx;
    logic [7:0]  expA;
    logic [7:0]  expB;
    logic [15:0] expHl;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [2:0]  rd_a_sel, rd_b_sel, wr_sel;
  logic [7:0]  rd_a_data, rd_b_data, wr_data, flag_data;
  logic        wr_en, flag_we, ex_af, exx;
  logic [15:0] hl_out;

  int checkCount;
  int failCount;
  vec_t vecs[$];

  reg_file_8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_a_sel  (rd_a_sel),
    .rd_b_sel  (rd_b_sel),
    .rd_a_data (rd_a_data),
    .rd_b_data (rd_b_data),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .flag_we   (flag_we),
    .flag_data (flag_data),
    .ex_af     (ex_af),
    .exx       (exx),
    .hl_out    (hl_out)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [2:0] rdA, input logic [2:0] rdB,
                              input logic wrEn, input logic [2:0] wrSel, input logic [7:0] wrData,
                              input logic flagWe, input logic [7:0] flagData,
                              input logic exAf, input logic exxS,
                              input logic [7:0] expA, input logic [7:0] expB, input logic [15:0] expHl);
    vec_t v;
    v.rdA = rdA; v.rdB = rdB; v.wrEn = wrEn; v.wrSel = wrSel; v.wrData = wrData;
    v.flagWe = flagWe; v.flagData = flagData; v.exAf = exAf; v.exx = exxS;
    v.expA = expA; v.expB = expB; v.expHl = expHl;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic clearInputs();
    rd_a_sel = 3'd0; rd_b_sel = 3'd0; wr_en = 1'b0; wr_sel = 3'd0; wr_data = 8'h00;
    flag_we = 1'b0; flag_data = 8'h00; ex_af = 1'b0; exx = 1'b0;
  endtask

  // Drive one vector at the falling edge, check just after the next rising edge
  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    rd_a_sel = v.rdA; rd_b_sel = v.rdB; wr_en = v.wrEn; wr_sel = v.wrSel; wr_data = v.wrData;
    flag_we = v.flagWe; flag_data = v.flagData; ex_af = v.exAf; exx = v.exx;
    @(posedge clk);
    #1;
    checkOutput($sformatf("vec%0d rd_a_data", idx), {8'h00, rd_a_data}, {8'h00, v.expA});
    checkOutput($sformatf("vec%0d rd_b_data", idx), {8'h00, rd_b_data}, {8'h00, v.expB});
    checkOutput($sformatf("vec%0d hl_out", idx), hl_out, v.expHl);
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    clearInputs();
    rst_n = 1'b0;

    //        rdA rdB wE wS  wD     fW fD     xA xx  expA   expB   expHl
    vecs.push_back(mk(7, 6, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'hFF, 8'hFF, 16'h0000));
    vecs.push_back(mk(0, 1, 1, 0, 8'h07, 0, 8'h00, 0, 0, 8'h07, 8'h00, 16'h0000));
    vecs.push_back(mk(0, 1, 1, 1, 8'h07, 0, 8'h00, 0, 0, 8'h07, 8'h07, 16'h0000));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h07, 8'h07, 16'h0000));
    vecs.push_back(mk(4, 5, 1, 4, 8'h12, 0, 8'h00, 0, 0, 8'h12, 8'h00, 16'h1200));
    vecs.push_back(mk(6, 7, 1, 6, 8'hAA, 1, 8'h45, 0, 0, 8'h45, 8'hFF, 16'h1200));
    vecs.push_back(mk(6, 2, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h45, 8'h00, 16'h1200));
    vecs.push_back(mk(6, 4, 1, 6, 8'h3C, 0, 8'h00, 0, 0, 8'h3C, 8'h12, 16'h1200));
    vecs.push_back(mk(5, 6, 1, 5, 8'h34, 0, 8'h00, 0, 0, 8'h34, 8'h3C, 16'h1234));
    vecs.push_back(mk(7, 0, 1, 7, 8'h11, 0, 8'h00, 0, 0, 8'h11, 8'h07, 16'h1234));
    vecs.push_back(mk(7, 6, 0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h11, 8'h3C, 16'h1234));
    vecs.push_back(mk(7, 6, 1, 7, 8'h22, 0, 8'h00, 0, 0, 8'h22, 8'hFF, 16'h1234));
    vecs.push_back(mk(7, 6, 0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h22, 8'hFF, 16'h1234));
    vecs.push_back(mk(7, 6, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h11, 8'h3C, 16'h1234));
    vecs.push_back(mk(7, 6, 0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h11, 8'h3C, 16'h1234));
    vecs.push_back(mk(7, 6, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h22, 8'hFF, 16'h1234));
    vecs.push_back(mk(6, 7, 0, 0, 8'h00, 1, 8'h5A, 1, 0, 8'h5A, 8'h22, 16'h1234));
    vecs.push_back(mk(6, 7, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h3C, 8'h11, 16'h1234));
    vecs.push_back(mk(6, 7, 0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h3C, 8'h11, 16'h1234));
    vecs.push_back(mk(6, 7, 0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h5A, 8'h22, 16'h1234));
    vecs.push_back(mk(6, 7, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h3C, 8'h11, 16'h1234));
    vecs.push_back(mk(4, 5, 1, 4, 8'h80, 0, 8'h00, 0, 0, 8'h80, 8'h34, 16'h8034));
    vecs.push_back(mk(5, 4, 1, 5, 8'h01, 0, 8'h00, 0, 0, 8'h01, 8'h80, 16'h8001));
    vecs.push_back(mk(5, 0, 1, 5, 8'h55, 0, 8'h00, 0, 1, 8'h55, 8'h07, 16'h0000));
    vecs.push_back(mk(0, 4, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 16'h0000));
    vecs.push_back(mk(2, 3, 1, 2, 8'h9A, 0, 8'h00, 0, 0, 8'h9A, 8'h00, 16'h0000));
    vecs.push_back(mk(2, 5, 0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h9A, 8'h00, 16'h8055));
    vecs.push_back(mk(2, 5, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h55, 16'h8055));
    vecs.push_back(mk(7, 4, 0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h11, 8'h80, 16'h0000));
    vecs.push_back(mk(7, 2, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h22, 8'h9A, 16'h0000));
    vecs.push_back(mk(7, 2, 0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h22, 8'h9A, 16'h8055));
    vecs.push_back(mk(7, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h11, 8'h07, 16'h8055));
    vecs.push_back(mk(3, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h07, 16'h8055));

    // Reset state while rst_n is held low
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset rd_a_data", {8'h00, rd_a_data}, 16'h0000);
    checkOutput("reset rd_b_data", {8'h00, rd_b_data}, 16'h0000);
    checkOutput("reset hl_out", hl_out, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i);
    end

    // Asynchronous reset mid-cycle with a write and both swaps in flight
    @(negedge clk);
    rd_a_sel = 3'd0; rd_b_sel = 3'd7;
    wr_en = 1'b1; wr_sel = 3'd0; wr_data = 8'h77; ex_af = 1'b1; exx = 1'b1;
    #2;
    checkOutput("pre-reset hl_out", hl_out, 16'h8055);
    checkOutput("pre-reset rd_b_data", {8'h00, rd_b_data}, 16'h0007);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset hl_out", hl_out, 16'h0000);
    checkOutput("async reset rd_b_data", {8'h00, rd_b_data}, 16'h0000);
    // Strobes stay high across edges while in reset and must be ignored
    repeat (2) @(posedge clk);
    #1;
    checkOutput("held reset hl_out", hl_out, 16'h0000);
    @(negedge clk);
    clearInputs();
    rst_n = 1'b1;
    #1;
    checkOutput("post-reset rd_a_data", {8'h00, rd_a_data}, 16'h0000);

    // After reset: discarded write, reset A/F values, cleared registers
    applyStimulus(mk(0, 7, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'hFF, 16'h0000), 100);
    applyStimulus(mk(6, 5, 1, 4, 8'hAB, 0, 8'h00, 0, 0, 8'hFF, 8'h00, 16'hAB00), 101);
    applyStimulus(mk(4, 2, 0, 0, 8'h00, 0, 8'h00, 0, 1, 8'hAB, 8'h00, 16'h0000), 102);
    applyStimulus(mk(7, 6, 0, 0, 8'h00, 0, 8'h00, 0, 1, 8'hFF, 8'hFF, 16'hAB00), 103);

    @(negedge clk);
    clearInputs();
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
